// File: rtl/gcm_pkg.sv
// Shared types and helpers for the GCM counter-block generator.
package gcm_pkg;

    localparam int unsigned CTR_W = 32;

    typedef enum logic [0:0] {
        IDLE,
        RUN
    } ctr_state_t;

    // Operates on the counter word only; callers concatenate the IV around the
    // result, so a wrap from 0xFFFFFFFF to 0 can never carry into the IV.
    function automatic logic [CTR_W-1:0] inc32(input logic [CTR_W-1:0] ctr,
                                               input logic [CTR_W-1:0] n);
        return ctr + n;
    endfunction

endpackage

// File: rtl/gcm_ctr_lanes.sv
// Combinational lane builder: expands IV, base counter and remaining count into
// LANES counter blocks with lane mask and last flag.
module gcm_ctr_lanes
    import gcm_pkg::*;
#(
    parameter int unsigned IV_W  = 96,
    parameter int unsigned LANES = 1,
    parameter int unsigned NB_W  = 32
) (
    input  logic [IV_W-1:0]                  iv,
    input  logic [CTR_W-1:0]                 ctr,
    input  logic [NB_W-1:0]                  rem,
    output logic [LANES*(IV_W+CTR_W)-1:0]    cb,
    output logic [LANES-1:0]                 lane_mask,
    output logic                             last
);

    localparam int unsigned BLK_W = IV_W + CTR_W;

    always_comb begin
        cb        = '0;
        lane_mask = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (rem > NB_W'(k)) begin
                lane_mask[k]            = 1'b1;
                cb[k*BLK_W +: BLK_W]    = {iv, inc32(ctr, CTR_W'(k))};
            end
        end
        last = (rem <= NB_W'(LANES));
    end

endmodule

// File: rtl/gcm_ctr_gen.sv
// GCM counter-block generator: accepts (IV, block count), latches J0 and emits
// LANES incrementing counter blocks per beat under valid/ready with flush.
module gcm_ctr_gen
    import gcm_pkg::*;
#(
    parameter int unsigned IV_W  = 96,
    parameter int unsigned LANES = 1,
    parameter int unsigned NB_W  = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_valid,
    output logic                                 o_ready,
    input  logic [IV_W-1:0]                      i_iv,
    input  logic [NB_W-1:0]                      i_num_blocks,
    input  logic                                 i_flush,
    output logic                                 o_valid,
    input  logic                                 i_ready,
    output logic [LANES*(IV_W+CTR_W)-1:0]        o_cb,
    output logic [LANES-1:0]                     o_lane_mask,
    output logic                                 o_last,
    output logic [IV_W+CTR_W-1:0]                o_j0,
    output logic                                 o_busy
);

    localparam int unsigned BLK_W = IV_W + CTR_W;

    ctr_state_t               state_q, state_d;
    logic [CTR_W-1:0]         ctr_q, ctr_d;
    logic [NB_W-1:0]          rem_q, rem_d;
    logic [IV_W-1:0]          iv_q, iv_d;
    logic [BLK_W-1:0]         j0_q, j0_d;
    logic                     valid_q, valid_d;
    logic [LANES*BLK_W-1:0]   cb_q;
    logic [LANES-1:0]         mask_q;
    logic                     last_q;

    logic [LANES*BLK_W-1:0]   lane_cb;
    logic [LANES-1:0]         lane_mask;
    logic                     lane_last;
    logic                     hs;
    logic                     accept;

    always_comb begin
        hs      = valid_q && i_ready;
        o_ready = !rst && !i_flush && (state_q == IDLE || (hs && last_q));
        accept  = i_valid && o_ready;

        state_d = state_q;
        ctr_d   = ctr_q;
        rem_d   = rem_q;
        iv_d    = iv_q;
        j0_d    = j0_q;
        valid_d = valid_q;

        if (state_q == RUN && i_flush) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            if (hs) begin
                ctr_d = inc32(ctr_q, CTR_W'(LANES));
                rem_d = rem_q - NB_W'(LANES);
                if (last_q) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            // Evaluated after the handshake so a zero-bubble accept overrides it.
            if (accept) begin
                j0_d = {i_iv, CTR_W'(1)};
                if (i_num_blocks != '0) begin
                    iv_d    = i_iv;
                    ctr_d   = CTR_W'(2);
                    rem_d   = i_num_blocks;
                    state_d = RUN;
                    valid_d = 1'b1;
                end
            end
        end
    end

    // Lanes are built from next-state values so the beat registers load directly.
    gcm_ctr_lanes #(
        .IV_W  (IV_W),
        .LANES (LANES),
        .NB_W  (NB_W)
    ) u_lanes (
        .iv        (iv_d),
        .ctr       (ctr_d),
        .rem       (rem_d),
        .cb        (lane_cb),
        .lane_mask (lane_mask),
        .last      (lane_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ctr_q   <= '0;
            rem_q   <= '0;
            iv_q    <= '0;
            j0_q    <= '0;
            valid_q <= 1'b0;
            cb_q    <= '0;
            mask_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            rem_q   <= rem_d;
            iv_q    <= iv_d;
            j0_q    <= j0_d;
            valid_q <= valid_d;
            cb_q    <= valid_d ? lane_cb : '0;
            mask_q  <= valid_d ? lane_mask : '0;
            last_q  <= valid_d ? lane_last : 1'b0;
        end
    end

    assign o_valid     = valid_q;
    assign o_cb        = cb_q;
    assign o_lane_mask = mask_q;
    assign o_last      = last_q;
    assign o_j0        = j0_q;
    assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_gcm_ctr_gen.sv
// Bench for gcm_ctr_gen: three instances (1, 4 and 2 lanes) checked against a
// queue of expected counter values per request.
module tb_gcm_ctr_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         rdy;
    logic         flush;
    logic [95:0]  iv;
    logic [39:0]  nb;
    int           sel;

    logic         vin [3];
    logic         fl [3];
    logic         ordy [3];
    logic         ovld [3];
    logic         olast [3];
    logic         obusy [3];
    logic [127:0] oj0 [3];
    logic [127:0] cb0;
    logic [511:0] cb1;
    logic [255:0] cb2;
    logic [0:0]   mask0;
    logic [3:0]   mask1;
    logic [1:0]   mask2;

    logic         m_ready, m_valid, m_last, m_busy;
    logic [511:0] m_cb;
    logic [3:0]   m_mask;
    logic [127:0] m_j0;

    int           checks = 0;
    int           errors = 0;
    logic [31:0]  exp_q [$];
    logic [95:0]  exp_iv;
    logic [127:0] exp_j0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            vin[k] = req_valid && (sel == k);
            fl[k]  = flush && (sel == k);
        end
        m_ready = ordy[sel];
        m_valid = ovld[sel];
        m_last  = olast[sel];
        m_busy  = obusy[sel];
        m_j0    = oj0[sel];
        case (sel)
            0:       begin m_cb = 512'(cb0); m_mask = 4'(mask0); end
            1:       begin m_cb = cb1;       m_mask = mask1;     end
            default: begin m_cb = 512'(cb2); m_mask = 4'(mask2); end
        endcase
    end

    gcm_ctr_gen #(.IV_W(96), .LANES(1), .NB_W(32)) u_l1 (
        .clk(clk), .rst(rst), .i_valid(vin[0]), .o_ready(ordy[0]), .i_iv(iv),
        .i_num_blocks(nb[31:0]), .i_flush(fl[0]), .o_valid(ovld[0]), .i_ready(rdy),
        .o_cb(cb0), .o_lane_mask(mask0), .o_last(olast[0]), .o_j0(oj0[0]), .o_busy(obusy[0])
    );

    gcm_ctr_gen #(.IV_W(96), .LANES(4), .NB_W(40)) u_l4 (
        .clk(clk), .rst(rst), .i_valid(vin[1]), .o_ready(ordy[1]), .i_iv(iv),
        .i_num_blocks(nb), .i_flush(fl[1]), .o_valid(ovld[1]), .i_ready(rdy),
        .o_cb(cb1), .o_lane_mask(mask1), .o_last(olast[1]), .o_j0(oj0[1]), .o_busy(obusy[1])
    );

    gcm_ctr_gen #(.IV_W(96), .LANES(2), .NB_W(32)) u_l2 (
        .clk(clk), .rst(rst), .i_valid(vin[2]), .o_ready(ordy[2]), .i_iv(iv),
        .i_num_blocks(nb[31:0]), .i_flush(fl[2]), .o_valid(ovld[2]), .i_ready(rdy),
        .o_cb(cb2), .o_lane_mask(mask2), .o_last(olast[2]), .o_j0(oj0[2]), .o_busy(obusy[2])
    );

    function automatic int lanes_of(input int s);
        case (s)
            0:       return 1;
            1:       return 4;
            default: return 2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected beat: the next LANES entries of the queue, lane 0 lowest.
    task automatic check_beat(input string tag);
        int           l;
        logic [511:0] ecb;
        logic [3:0]   em;
        l   = lanes_of(sel);
        ecb = '0;
        em  = '0;
        for (int k = 0; k < l; k++) begin
            if (k < exp_q.size()) begin
                em[k]              = 1'b1;
                ecb[k*128 +: 128]  = {exp_iv, exp_q[k]};
            end
        end
        chk({tag, " valid"}, m_valid, 1'b1);
        chk({tag, " cb"}, m_cb, ecb);
        chk({tag, " mask"}, m_mask, em);
        chk({tag, " last"}, m_last, exp_q.size() <= l);
        chk({tag, " j0"}, m_j0, exp_j0);
        chk({tag, " busy"}, m_busy, 1'b1);
    endtask

    task automatic pop_beat();
        for (int k = 0; k < lanes_of(sel); k++) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
    endtask

    task automatic send(input string tag, input logic [95:0] iv_v, input logic [39:0] n);
        bit ok;
        logic [31:0] c;
        ok        = 1'b0;
        req_valid = 1'b1;
        iv        = iv_v;
        nb        = n;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (m_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, " accept"}, ok, 1'b1);
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        exp_iv    = iv_v;
        exp_j0    = {iv_v, 32'd1};
        exp_q.delete();
        c = 32'd2;
        for (longint i = 0; i < longint'(n) && i < 64; i++) begin
            exp_q.push_back(c);
            c = c + 32'd1;
        end
    endtask

    task automatic drain(input string tag, input int stall_pct);
        for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
            check_beat(tag);
            rdy = ($urandom_range(99) >= stall_pct);
            @(posedge clk);
            if (rdy) pop_beat();
            @(negedge clk);
        end
        chk({tag, " drained"}, exp_q.size() == 0, 1'b1);
        chk({tag, " idle valid"}, m_valid, 1'b0);
        chk({tag, " idle busy"}, m_busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        rst       = 1'b1;
        req_valid = 1'b0;
        rdy       = 1'b0;
        flush     = 1'b0;
        iv        = '0;
        nb        = '0;
        sel       = 0;
        exp_iv    = '0;
        exp_j0    = '0;
        repeat (2) @(negedge clk);

        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("rst ready", m_ready, 1'b0);
            chk("rst valid", m_valid, 1'b0);
            chk("rst cb", m_cb, '0);
            chk("rst mask", m_mask, '0);
            chk("rst last", m_last, 1'b0);
            chk("rst j0", m_j0, '0);
            chk("rst busy", m_busy, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        sel = 0;
        #1;
        chk("ready after rst", m_ready, 1'b1);

        // One lane, three blocks.
        sel = 0;
        send("A", 96'hCAFEBABE_FACEDBAD_DECAF888, 40'd3);
        chk("A j0 low word", m_j0[31:0], 32'd1);
        drain("A", 0);

        // Four lanes, partial second beat.
        sel = 1;
        send("B", 96'h0123_4567_89AB_CDEF_0011_2233, 40'd6);
        drain("B", 0);

        // Counter wrap: jump the base counter so the next beat starts at 0xFFFFFFFE.
        sel = 1;
        send("C", 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 40'h1_0000_0003);
        check_beat("C first");
        force u_l4.ctr_q = 32'hFFFF_FFFA;
        rdy = 1'b1;
        @(posedge clk);
        #1;
        release u_l4.ctr_q;
        exp_q.delete();
        w = 32'hFFFF_FFFE;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(w);
            w = w + 32'd1;
        end
        @(negedge clk);
        check_beat("C wrap");
        flush = 1'b1;
        rdy   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        exp_q.delete();
        chk("C flushed valid", m_valid, 1'b0);
        chk("C flushed busy", m_busy, 1'b0);

        // Backpressure holds beat 1 for five cycles.
        sel = 2;
        send("D", 96'hAAAA_5555_AAAA_5555_AAAA_5555, 40'd4);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_beat("D stall");
            @(negedge clk);
        end
        drain("D", 0);

        // Zero-bubble accept of a zero-length request, then a one-block request.
        sel = 0;
        rdy = 1'b1;
        send("E a", 96'h1111_2222_3333_4444_5555_6666, 40'd2);
        check_beat("E a1");
        @(posedge clk);
        pop_beat();
        @(negedge clk);
        check_beat("E a2");
        req_valid = 1'b1;
        iv        = 96'h7777_8888_9999_AAAA_BBBB_CCCC;
        nb        = 40'd0;
        #1;
        chk("E ready on last hs", m_ready, 1'b1);
        @(posedge clk);
        pop_beat();
        @(negedge clk);
        chk("E no beat for B", m_valid, 1'b0);
        chk("E B j0", m_j0, {96'h7777_8888_9999_AAAA_BBBB_CCCC, 32'd1});
        iv = 96'hDDDD_EEEE_FFFF_0000_1234_5678;
        nb = 40'd1;
        #1;
        chk("E ready for C", m_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        exp_iv    = 96'hDDDD_EEEE_FFFF_0000_1234_5678;
        exp_j0    = {exp_iv, 32'd1};
        exp_q.push_back(32'd2);
        drain("E c", 0);

        // Flush during the last beat with a request waiting.
        sel = 1;
        rdy = 1'b1;
        send("F", 96'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F, 40'd8);
        check_beat("F b1");
        @(posedge clk);
        pop_beat();
        @(negedge clk);
        check_beat("F b2");
        flush     = 1'b1;
        req_valid = 1'b1;
        iv        = 96'h9999_0000_9999_0000_9999_0000;
        nb        = 40'd3;
        #1;
        chk("F ready during flush", m_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        exp_q.delete();
        chk("F flushed valid", m_valid, 1'b0);
        chk("F j0 kept", m_j0, {96'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F, 32'd1});
        send("F g", 96'h9999_0000_9999_0000_9999_0000, 40'd3);
        drain("F g", 20);

        // Reset in the middle of an instance.
        sel = 2;
        send("G", 96'h1357_9BDF_2468_ACE0_1357_9BDF, 40'd6);
        rdy = 1'b0;
        check_beat("G b1");
        rst = 1'b1;
        #1;
        chk("G ready in rst", m_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("G rst valid", m_valid, 1'b0);
        chk("G rst cb", m_cb, '0);
        chk("G rst mask", m_mask, '0);
        chk("G rst last", m_last, 1'b0);
        chk("G rst j0", m_j0, '0);
        chk("G rst busy", m_busy, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("G ready after rst", m_ready, 1'b1);

        // Randomised requests with random backpressure.
        for (int r = 0; r < 12; r++) begin
            @(negedge clk);
            sel = int'($urandom_range(2));
            send("R", {$urandom, $urandom, $urandom}, 40'($urandom_range(9)));
            drain("R", 25);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcm_ctr_gen.md
# gcm_ctr_gen

Parametrised GCM counter-block generator feeding the AES pipeline's CTR-mode datapath. It accepts one instance request (IV plus block count), then emits J0 and a stream of incrementing counter blocks. Blocks are emitted LANES per beat under a valid/ready handshake with backpressure, flush, and correct inc32 wrap-around. It replaces the single-lane, free-running cb/J0 logic of the earlier pipeline stage.

## Interface
Parameters:
- IV_W, 96, IV width; counter field width is fixed at 32; block width BLK_W = IV_W+32.
- LANES, 1, counter blocks per output beat (1..8).
- NB_W, 32, width of the block-count field.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  request valid.
- o_ready  out  1  request accepted when i_valid && o_ready.
- i_iv  in  IV_W  instance IV.
- i_num_blocks  in  NB_W  counter blocks to emit for this instance (J0 not counted).
- i_flush  in  1  abort current instance.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts beat.
- o_cb  out  LANES*BLK_W  lane k at bits [k*BLK_W +: BLK_W]; lane 0 holds the lowest counter.
- o_lane_mask  out  LANES  bit k set when lane k carries a real block.
- o_last  out  1  final beat of the instance.
- o_j0  out  BLK_W  {IV, 32'd1} of the current instance.
- o_busy  out  1  state != IDLE.

## Operation
- States: IDLE, RUN.
- IDLE, on accept with i_num_blocks == 0: latch o_j0, stay IDLE, emit no beat.
- IDLE, on accept with i_num_blocks != 0:
  - latch o_j0 = {i_iv, 32'd1};
  - ctr = 2; rem = i_num_blocks; go RUN.
- RUN: beat registers hold lane k = {IV, ctr+k mod 2^32}.
  - o_lane_mask bit k = (k < rem).
  - Masked lanes drive all zeros.
  - o_last = (rem <= LANES).
- Handshake (o_valid && i_ready):
  - ctr += LANES mod 2^32; rem -= LANES.
  - If o_last, go IDLE.
- inc32 rule: only the low 32 bits increment. 0xFFFFFFFF wraps to 0x00000000 with no carry into the IV. This applies per lane within a beat and across beats.
- o_ready = !rst && (IDLE || (RUN && o_valid && i_ready && o_last)).
  - A new request may be accepted in the same cycle as the last handshake (zero-bubble).
  - When that happens, the accept takes effect and the next instance's first beat appears the next cycle.
- i_flush (RUN): next cycle state = IDLE, o_valid = 0. Any beat presented that cycle counts as not delivered. o_ready is 0 while i_flush is high.
- i_flush in IDLE: no effect.
- rst dominates flush and accept.
- o_j0 holds its value until the next accept.

## Timing
- Reset values: o_valid 0, o_cb 0, o_lane_mask 0, o_last 0, o_j0 0, o_busy 0, state IDLE.
- o_ready is 0 during rst and 1 in the first cycle after rst deasserts.
- Latency: accept at edge T gives o_valid = 1 and the first beat stable after T.
- All beat outputs are registered.
- While o_valid && !i_ready, o_cb, o_lane_mask and o_last hold stable.
- Beat count per instance = ceil(N/LANES). Sustained throughput is LANES blocks/cycle with i_ready held high.
- A request with i_valid high while o_ready is low is not consumed. The requester holds it.

## Structure
- gcm_pkg holds:
  - localparam CTR_W = 32;
  - function inc32(blk, n): add n to the low 32 bits, IV untouched;
  - state enum ctr_state_t {IDLE, RUN}.
- One sub-module, gcm_ctr_lanes: combinational. Inputs are the IV, base ctr and rem; outputs are the LANES masked blocks, lane mask and last flag. It is instantiated once, in front of the beat registers.
- Top holds the FSM, ctr/rem registers, J0 register and handshake.

## Test plan
- LANES=1, IV=0xCAFEBABE_FACEDBAD_DECAF888, N=3, i_ready=1 → o_j0 low word 1. Beats carry ctr 2, 3, 4, each with mask 1; o_last on the third beat; then IDLE.
- LANES=4, N=6 → beat 1 carries ctr 2..5 with mask 4'b1111, o_last 0. Beat 2 carries ctr 6, 7, mask 4'b0011, lanes 2–3 zero, o_last 1.
- LANES=4, first ctr forced near wrap via N=0x1_0000_0003 (NB_W=40); checked on the beat whose base ctr is 0xFFFFFFFE → lanes carry 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001, with the IV bits unchanged.
- Backpressure: LANES=2, N=4, i_ready low for 5 cycles during beat 1 → beat 1 (ctr 2, 3) held constant for 5 cycles; beat 2 (ctr 4, 5) follows the first i_ready cycle.
- Zero-bubble plus zero-length: request A (N=2) with request B (N=0) then C (N=1, new IV) waiting. B is accepted on A's last handshake, and C is accepted the next cycle. C's beat appears the following cycle with C's J0 and ctr 2; no beat is ever emitted for B.
- Flush, then reset mid-RUN: i_flush during beat 2 of N=8 → o_valid 0 next cycle, then a new request is accepted. rst during RUN → all outputs zero next cycle, and o_ready is 1 after rst drops.
